// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: FSM state and E-stage operand-forward select.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, LOAD_STALL, REDIRECT, MEM_WAIT} hz_state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_fwd_sel.sv
// One E-stage operand forward select; the M-stage result wins over W when both match.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] Rs,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_t   sel
);
  always_comb begin
    if (RegWriteM && RdM != REG_ZERO && RdM == Rs)      sel = FWD_MEM;
    else if (RegWriteW && RdW != REG_ZERO && RdW == Rs) sel = FWD_WB;
    else                                                sel = FWD_RF;
  end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/forward control with a small FSM for multi-cycle bubbles.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_cycles counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY    = 1,
  parameter int REDIRECT_CYCLES = 0,
  parameter int PERF_WIDTH      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       MemReadE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCTakenE,
  input  logic       MemAccessM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cycles,
  output logic [PERF_WIDTH-1:0] flush_cycles
`endif
);
  localparam bit CFG_OK = LOAD_LATENCY >= 1 && LOAD_LATENCY <= 3 &&
                          REDIRECT_CYCLES >= 0 && REDIRECT_CYCLES <= 3 && PERF_WIDTH >= 1;

  // operand A/B selects: lane 0 = Rs1E, lane 1 = Rs2E
  logic [1:0][4:0] rs_e;
  fwd_sel_t        fwd [2];
  assign rs_e = {Rs2E, Rs1E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    hazard_fwd_sel u_sel (
      .Rs(rs_e[i]), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .sel(fwd[i])
    );
  end

  assign ForwardAE = rst_n ? fwd[0] : FWD_RF;
  assign ForwardBE = rst_n ? fwd[1] : FWD_RF;

  logic load_use, mem_wait;
  assign load_use = MemReadE && RdE != REG_ZERO && (RdE == Rs1D || RdE == Rs2D);
  assign mem_wait = MemAccessM && !MemReadyM;

  hz_state_t  state, state_n, saved, saved_n, eff;
  logic [1:0] cnt, cnt_n;
  logic       sf, sd, se, sm, fd, fe;

  // MEM_WAIT freezes whatever was in progress; in the ready cycle the saved
  // state is decoded directly, so a held redirect or stall resumes at once.
  always_comb begin
    eff     = (state == MEM_WAIT) ? saved : state;
    state_n = state;
    saved_n = saved;
    cnt_n   = cnt;
    {sf, sd, se, sm, fd, fe} = '0;
    if (mem_wait) begin
      {sf, sd, se, sm} = '1;
      state_n = MEM_WAIT;
      saved_n = eff;
    end else begin
      saved_n = RUN;
      case (eff)
        LOAD_STALL: begin
          {sf, sd, fe} = '1;
          cnt_n   = cnt - 2'd1;
          state_n = (cnt == 2'd1) ? RUN : LOAD_STALL;
        end
        REDIRECT: begin
          fd      = 1'b1;
          cnt_n   = cnt - 2'd1;
          state_n = (cnt == 2'd1) ? RUN : REDIRECT;
        end
        default: begin
          state_n = RUN;
          if (PCTakenE) begin
            {fd, fe} = '1;
            if (REDIRECT_CYCLES > 0) begin
              cnt_n   = 2'(REDIRECT_CYCLES);
              state_n = REDIRECT;
            end
          end else if (load_use) begin
            {sf, sd, fe} = '1;
            if (LOAD_LATENCY > 1) begin
              cnt_n   = 2'(LOAD_LATENCY - 1);
              state_n = LOAD_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      cnt   <= cnt_n;
    end
  end

  // reset forces bubbles into D/E and releases every hold
  assign StallF = rst_n & sf;
  assign StallD = rst_n & sd;
  assign StallE = rst_n & se;
  assign StallM = rst_n & sm;
  assign FlushD = !rst_n | fd;
  assign FlushE = !rst_n | fe;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (StallF && !(&stall_cycles)) stall_cycles <= stall_cycles + PERF_WIDTH'(1);
      if (FlushE && !(&flush_cycles)) flush_cycles <= flush_cycles + PERF_WIDTH'(1);
    end
  end
`endif

  a_legal: assert property (@(posedge clk) disable iff (!rst_n)
    CFG_OK && !(PCTakenE && load_use));
endmodule
